ddr_cmd_seq: RTL and testbench

DDR_CMD_SEQ -- requirements
Module: ddr_cmd_seq

---
 rtl/ddr_cmd_seq.sv | 162 ++++++++++++++++
 tb/tb_ddr_cmd_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_seq.sv
// Strided-row DDR command sequencer: descriptor FIFO feeding a row-issue FSM for an AXI data engine.
// Optional alignment/length checking of descriptors is enabled with `define DDR_CMD_SEQ_CHK_EN.
module ddr_cmd_seq #(
  parameter int C_AXI_ADDR_WIDTH = 64,
  parameter int SINGLE_LEN       = 24,
  parameter int ROW_W            = 16,
  parameter int DESC_DEPTH       = 4,
  parameter int BEAT_BYTES       = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        desc_valid,
  output logic                        desc_ready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] desc_addr,
  input  logic [C_AXI_ADDR_WIDTH-1:0] desc_stride,
  input  logic [SINGLE_LEN-1:0]       desc_row_len,
  input  logic [ROW_W-1:0]            desc_rows,
  input  logic                        desc_type,
  output logic [C_AXI_ADDR_WIDTH-1:0] ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]       ddr_len,
  output logic                        ddr_conf,
  output logic                        cmd_type,
  input  logic                        ddr_idle,
  output logic                        desc_done,
  output logic                        busy,
  output logic                        err
);

  localparam int PW   = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int BB_W = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 1;

  typedef struct packed {
    logic [C_AXI_ADDR_WIDTH-1:0] addr;
    logic [C_AXI_ADDR_WIDTH-1:0] stride;
    logic [SINGLE_LEN-1:0]       len;
    logic [ROW_W-1:0]            rows;
    logic                        typ;
  } desc_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_STEP} state_t;

  state_t state, state_d;

  desc_t         fifo_mem [DESC_DEPTH];
  desc_t         head, in_d;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop, fifo_empty;

  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, stride_q;
  logic [SINGLE_LEN-1:0]       len_q;
  logic [ROW_W-1:0]            rows_q;
  logic                        type_q, done_q;
  logic                        misalign, head_bad;

  // ---------------- descriptor FIFO ----------------
  assign in_d       = '{addr: desc_addr, stride: desc_stride, len: desc_row_len,
                        rows: desc_rows, typ: desc_type};
  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (count == '0);
  // Ready depends only on occupancy so a same-cycle pop never creates a ready->valid path.
  assign desc_ready = (count != (PW+1)'(DESC_DEPTH));
  assign push       = desc_valid && desc_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- descriptor checking ----------------
  assign misalign = (|head.addr[BB_W-1:0]) | (|head.stride[BB_W-1:0]) | (|head.len[BB_W-1:0]);

`ifdef DDR_CMD_SEQ_CHK_EN
  logic err_q;
  assign head_bad = misalign || ((head.len == '0) && (head.rows != '0));
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n)               err_q <= 1'b0;
    else if (pop && head_bad) err_q <= 1'b1;
  end
`else
  logic unused_chk;
  assign unused_chk = misalign;
  assign head_bad   = 1'b0;
  assign err        = 1'b0;
`endif

  // ---------------- row FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if ((head.rows != '0) && !head_bad) state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_GUARD;
      // Engine's idle flag is registered, so it still reads 1 the cycle after conf.
      S_GUARD: state_d = S_WAIT;
      S_WAIT:  if (ddr_idle) state_d = S_STEP;
      S_STEP:  state_d = (rows_q != ROW_W'(1)) ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      rows_q   <= '0;
      type_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) begin
        addr_q   <= head.addr;
        stride_q <= head.stride;
        len_q    <= head.len;
        rows_q   <= head.rows;
        type_q   <= head.typ;
        if ((head.rows == '0) || head_bad) done_q <= 1'b1;
      end
      if (state == S_STEP) begin
        rows_q <= rows_q - 1'b1;
        if (rows_q != ROW_W'(1)) addr_q <= addr_q + stride_q;
        else                     done_q <= 1'b1;
      end
    end
  end

  assign ddr_conf        = (state == S_ISSUE);
  assign ddr_st_addr_out = addr_q;
  assign ddr_len         = len_q;
  assign cmd_type        = type_q;
  assign desc_done       = done_q;
  assign busy            = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ddr_cmd_seq.sv
// Directed self-checking bench for ddr_cmd_seq with a simple latency model of the AXI engine.
module tb_ddr_cmd_seq;
  localparam int AW = 64;
  localparam int SL = 24;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          desc_valid = 1'b0;
  logic          desc_ready;
  logic [AW-1:0] desc_addr = '0;
  logic [AW-1:0] desc_stride = '0;
  logic [SL-1:0] desc_row_len = '0;
  logic [RW-1:0] desc_rows = '0;
  logic          desc_type = 1'b0;
  logic [AW-1:0] ddr_st_addr_out;
  logic [SL-1:0] ddr_len;
  logic          ddr_conf;
  logic          cmd_type;
  logic          ddr_idle = 1'b1;
  logic          desc_done;
  logic          busy;
  logic          err;

  ddr_cmd_seq dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_stride(desc_stride),
    .desc_row_len(desc_row_len), .desc_rows(desc_rows), .desc_type(desc_type),
    .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len), .ddr_conf(ddr_conf),
    .cmd_type(cmd_type), .ddr_idle(ddr_idle), .desc_done(desc_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SL-1:0] len;
    logic          typ;
    int            c;
  } conf_t;

  conf_t conf_q[$];
  int    done_q[$];
  int    checks = 0;
  int    errors = 0;

  // Engine model: idle drops when conf is seen, returns eng_lat cycles later unless held.
  bit eng_hold = 1'b0;
  int eng_lat  = 5;
  int eng_cnt  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      eng_cnt  = 0;
      ddr_idle = 1'b1;
    end else if (ddr_conf) begin
      eng_cnt  = eng_lat;
      ddr_idle = 1'b0;
    end else if (eng_cnt > 0 && !eng_hold) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) ddr_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ddr_conf) conf_q.push_back('{ddr_st_addr_out, ddr_len, cmd_type, cyc});
      if (desc_done) done_q.push_back(cyc);
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push(input logic [AW-1:0] a, input logic [AW-1:0] s, input logic [SL-1:0] l,
                      input logic [RW-1:0] r, input logic t, output int acc);
    desc_addr = a; desc_stride = s; desc_row_len = l; desc_rows = r; desc_type = t;
    desc_valid = 1'b1;
    for (int n = 0; n < 300 && !desc_ready; n++) @(negedge clk);
    acc = cyc;
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    conf_q.delete();
    done_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({desc_ready, ddr_conf, desc_done, busy, err, cmd_type} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 100000", {desc_ready, ddr_conf, desc_done, busy, err, cmd_type});
    end
    checks++;
    if (ddr_st_addr_out !== '0) begin
      errors++; $display("FAIL reset_addr got %h want 0", ddr_st_addr_out);
    end
    checks++;
    if (ddr_len !== '0) begin
      errors++; $display("FAIL reset_len got %h want 0", ddr_len);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [AW-1:0] exp_a [3];
    int acc;
    exp_a = '{64'h1000, 64'h1400, 64'h1800};
    settle();
    push(64'h1000, 64'h400, 24'd256, 16'd3, 1'b0, acc);
    for (int i = 0; i < 300 && done_q.size() < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (conf_q.size() != 3) begin
      errors++; $display("FAIL basic_nconf got %0d want 3", conf_q.size());
    end
    for (int i = 0; i < 3 && i < conf_q.size(); i++) begin
      checks++;
      if (conf_q[i].addr !== exp_a[i] || conf_q[i].len !== 24'd256 || conf_q[i].typ !== 1'b0) begin
        errors++;
        $display("FAIL basic_row%0d got addr %h len %0d typ %b want addr %h len 256 typ 0",
                 i, conf_q[i].addr, conf_q[i].len, conf_q[i].typ, exp_a[i]);
      end
      checks++;
      if (conf_q[i].c != acc + 2 + 7 * i) begin
        errors++; $display("FAIL basic_cyc%0d got %0d want %0d", i, conf_q[i].c, acc + 2 + 7 * i);
      end
    end
    checks++;
    if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != acc + 23)) begin
      errors++;
      $display("FAIL basic_done got n=%0d first=%0d want n=1 at %0d",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, acc + 23);
    end
  endtask

  task automatic test_zero_rows();
    int acc;
    settle();
    push(64'h5000, 64'h100, 24'd64, 16'd0, 1'b0, acc);
    repeat (6) @(negedge clk);
    checks++;
    if (conf_q.size() != 0) begin
      errors++; $display("FAIL zero_nconf got %0d want 0", conf_q.size());
    end
    checks++;
    if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != acc + 2)) begin
      errors++;
      $display("FAIL zero_done got n=%0d first=%0d want n=1 at %0d",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, acc + 2);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL zero_busy got %b want 0", busy);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [2];
    int acc;
    exp_a = '{64'hFFFF_FFFF_FFFF_FF00, 64'h100};
    settle();
    push(64'hFFFF_FFFF_FFFF_FF00, 64'h200, 24'd64, 16'd2, 1'b1, acc);
    for (int i = 0; i < 300 && done_q.size() < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (conf_q.size() != 2) begin
      errors++; $display("FAIL wrap_nconf got %0d want 2", conf_q.size());
    end
    for (int i = 0; i < 2 && i < conf_q.size(); i++) begin
      checks++;
      if (conf_q[i].addr !== exp_a[i] || conf_q[i].len !== 24'd64 || conf_q[i].typ !== 1'b1) begin
        errors++;
        $display("FAIL wrap_row%0d got addr %h len %0d typ %b want addr %h len 64 typ 1",
                 i, conf_q[i].addr, conf_q[i].len, conf_q[i].typ, exp_a[i]);
      end
    end
    checks++;
    if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != acc + 16)) begin
      errors++;
      $display("FAIL wrap_done got n=%0d first=%0d want n=1 at %0d",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, acc + 16);
    end
  endtask

  task automatic test_chk();
    int acc;
    settle();
`ifdef DDR_CMD_SEQ_CHK_EN
    push(64'h1010, 64'h400, 24'd256, 16'd1, 1'b0, acc);
    repeat (6) @(negedge clk);
    checks++;
    if (err !== 1'b1 || conf_q.size() != 0) begin
      errors++; $display("FAIL chk_reject got err=%b nconf=%0d want err=1 nconf=0", err, conf_q.size());
    end
    checks++;
    if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] != acc + 2)) begin
      errors++; $display("FAIL chk_done got n=%0d want n=1 at %0d", done_q.size(), acc + 2);
    end
    done_q.delete();
    push(64'h3000, 64'h0, 24'd64, 16'd1, 1'b1, acc);
    for (int i = 0; i < 300 && done_q.size() < 1; i++) @(negedge clk);
    checks++;
    if (conf_q.size() != 1 || (conf_q.size() > 0 && conf_q[0].addr !== 64'h3000) || err !== 1'b1) begin
      errors++; $display("FAIL chk_next got nconf=%0d err=%b want nconf=1 addr 3000 err=1", conf_q.size(), err);
    end
`else
    push(64'h1010, 64'h400, 24'd256, 16'd1, 1'b0, acc);
    for (int i = 0; i < 300 && done_q.size() < 1; i++) @(negedge clk);
    checks++;
    if (err !== 1'b0 || conf_q.size() != 1 || (conf_q.size() > 0 && conf_q[0].addr !== 64'h1010)) begin
      errors++; $display("FAIL nochk got err=%b nconf=%0d want err=0 nconf=1 addr 1010", err, conf_q.size());
    end
    checks++;
    if (conf_q.size() > 0 && conf_q[0].c != acc + 2) begin
      errors++; $display("FAIL nochk_lat got %0d want %0d", conf_q[0].c, acc + 2);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int acc, acc_f, rdy_seen;
    settle();
    eng_hold = 1'b1;
    push(64'h2000, 64'h0, 24'd32, 16'd1, 1'b0, acc);
    for (int k = 1; k <= 4; k++)
      push(64'h2000 + 64'(k) * 64'h1000, 64'h0, 24'd32, 16'd1, 1'b0, acc);
    checks++;
    if (desc_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_full got ready=%b busy=%b want ready=0 busy=1", desc_ready, busy);
    end
    // Fifth queued descriptor is offered while full; it must wait, not overwrite.
    desc_addr = 64'h7000; desc_stride = '0; desc_row_len = 24'd32; desc_rows = 16'd1; desc_type = 1'b0;
    desc_valid = 1'b1;
    rdy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (desc_ready) rdy_seen++;
    end
    checks++;
    if (rdy_seen != 0) begin
      errors++; $display("FAIL b2b_hold got ready_cycles=%0d want 0", rdy_seen);
    end
    eng_hold = 1'b0;
    for (int n = 0; n < 300 && !desc_ready; n++) @(negedge clk);
    acc_f = cyc;
    @(negedge clk);
    desc_valid = 1'b0;
    for (int i = 0; i < 500 && done_q.size() < 6; i++) @(negedge clk);
    checks++;
    if (done_q.size() < 1 || acc_f != done_q[0] + 1) begin
      errors++;
      $display("FAIL b2b_accept got %0d want %0d", acc_f, (done_q.size() > 0) ? done_q[0] + 1 : -1);
    end
    checks++;
    if (conf_q.size() != 6) begin
      errors++; $display("FAIL b2b_nconf got %0d want 6", conf_q.size());
    end
    for (int i = 0; i < 6 && i < conf_q.size(); i++) begin
      checks++;
      if (conf_q[i].addr !== 64'h2000 + 64'(i) * 64'h1000) begin
        errors++;
        $display("FAIL b2b_order%0d got %h want %h", i, conf_q[i].addr, 64'h2000 + 64'(i) * 64'h1000);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    settle();
    eng_lat = 20;
    push(64'h8000, 64'h100, 24'd32, 16'd3, 1'b1, acc);
    for (int i = 0; i < 300 && conf_q.size() < 2; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({desc_ready, ddr_conf, desc_done, busy, err, cmd_type} !== 6'b100000 ||
        ddr_st_addr_out !== '0 || ddr_len !== '0) begin
      errors++;
      $display("FAIL midrst_outs got ctrl=%b addr=%h len=%h want ctrl=100000 addr=0 len=0",
               {desc_ready, ddr_conf, desc_done, busy, err, cmd_type}, ddr_st_addr_out, ddr_len);
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (done_q.size() != 0 || conf_q.size() != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after got done=%0d nconf=%0d busy=%b want done=0 nconf=2 busy=0",
               done_q.size(), conf_q.size(), busy);
    end
    eng_lat = 5;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_rows();
    test_wrap();
    test_chk();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
